// File: rtl/cmd_frame_pkg.sv
// Shared constants and state encoding for the command frame decoder.
// Frame layout: SYNC, ADDR, LEN, LEN payload bytes, CHK.
package cmd_frame_pkg;

  localparam logic [7:0] SYNC = 8'hA5;

  localparam int FLD_SYNC = 0;
  localparam int FLD_ADDR = 1;
  localparam int FLD_LEN  = 2;

  // Header states are numbered by the field they expect next.
  typedef enum logic [2:0] {
    HUNT    = 3'(FLD_SYNC),
    ADDR    = 3'(FLD_ADDR),
    LEN     = 3'(FLD_LEN),
    PAYLOAD = 3'd3,
    CHECK   = 3'd4,
    DRAIN   = 3'd5
  } state_e;

endpackage

// File: rtl/cmd_frame_decoder_frame_buffer.sv
// Payload store: MAX_LEN x TXN_SZ registers, sync write, comb read.
// Ports: clock, we/widx/wdata write port, ridx/rdata read port.
module frame_buffer #(
  parameter int TXN_SZ  = 8,
  parameter int MAX_LEN = 16,
  parameter int AW      = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     widx,
  input  logic [TXN_SZ-1:0] wdata,
  input  logic [AW-1:0]     ridx,
  output logic [TXN_SZ-1:0] rdata
);

  logic [TXN_SZ-1:0] mem [MAX_LEN];

  always_ff @(posedge clock) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/cmd_frame_decoder.sv
// Frames deserializer bytes into checksummed register-write bursts.
// Ports: clock/reset, nd/data in, wr_* handshake out, status pulses.
module cmd_frame_decoder
  import cmd_frame_pkg::*;
#(
  parameter int TXN_SZ      = 8,
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              nd,
  input  logic [TXN_SZ-1:0] data,
  output logic              wr_en,
  output logic [TXN_SZ-1:0] wr_addr,
  output logic [TXN_SZ-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              frame_ok,
  output logic              chk_err,
  output logic              len_err,
  output logic              to_err,
  output logic              ovf_err
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e state_q, state_d;
  logic [TXN_SZ-1:0] base_q, base_d;
  logic [TXN_SZ-1:0] chk_q, chk_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] idx_nx;
  logic [TW-1:0] tmo_q, tmo_d;
  logic wr_en_q, wr_en_d;
  logic [TXN_SZ-1:0] wr_addr_q, wr_addr_d;
  logic [TXN_SZ-1:0] wr_data_q, wr_data_d;
  logic busy_q, busy_d;
  logic frame_ok_q, frame_ok_d;
  logic chk_err_q, chk_err_d;
  logic len_err_q, len_err_d;
  logic to_err_q, to_err_d;
  logic ovf_err_q, ovf_err_d;
  logic timed;
  logic buf_we;
  logic [AW-1:0] buf_ridx;
  logic [TXN_SZ-1:0] buf_rdata;

  frame_buffer #(
    .TXN_SZ (TXN_SZ),
    .MAX_LEN(MAX_LEN),
    .AW     (AW)
  ) u_buf (
    .clock(clock),
    .we   (buf_we),
    .widx (idx_q[AW-1:0]),
    .wdata(data),
    .ridx (buf_ridx),
    .rdata(buf_rdata)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    chk_d      = chk_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tmo_d      = '0;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    frame_ok_d = 1'b0;
    chk_err_d  = 1'b0;
    len_err_d  = 1'b0;
    to_err_d   = 1'b0;
    ovf_err_d  = 1'b0;
    buf_we     = 1'b0;
    idx_nx     = idx_q + 1'b1;
    buf_ridx   = idx_nx[AW-1:0];
    timed      = state_q inside {ADDR, LEN, PAYLOAD, CHECK};

    // An nd on the expiry cycle keeps the frame alive.
    if (timed && !nd) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        to_err_d = 1'b1;
        state_d  = HUNT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    unique case (state_q)
      HUNT: begin
        if (nd && data == TXN_SZ'(SYNC)) state_d = ADDR;
      end
      ADDR: begin
        if (nd) begin
          base_d  = data;
          chk_d   = data;
          state_d = LEN;
        end
      end
      LEN: begin
        if (nd) begin
          if (data == '0 || data > TXN_SZ'(MAX_LEN)) begin
            len_err_d = 1'b1;
            state_d   = HUNT;
          end else begin
            len_d   = data[LW-1:0];
            chk_d   = chk_q ^ data;
            idx_d   = '0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (nd) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ data;
          idx_d  = idx_nx;
          if (idx_nx == len_q) state_d = CHECK;
        end
      end
      CHECK: begin
        buf_ridx = '0;
        if (nd) begin
          if ((chk_q ^ data) == '0) begin
            frame_ok_d = 1'b1;
            idx_d      = '0;
            wr_en_d    = 1'b1;
            wr_addr_d  = base_q;
            wr_data_d  = buf_rdata;
            state_d    = DRAIN;
          end else begin
            chk_err_d = 1'b1;
            state_d   = HUNT;
          end
        end
      end
      DRAIN: begin
        ovf_err_d = nd;
        if (wr_ready) begin
          idx_d = idx_nx;
          if (idx_nx == len_q) begin
            wr_en_d   = 1'b0;
            wr_addr_d = '0;
            wr_data_d = '0;
            state_d   = HUNT;
          end else begin
            wr_addr_d = base_q + TXN_SZ'(idx_nx);
            wr_data_d = buf_rdata;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    busy_d = (state_d != HUNT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      base_q     <= '0;
      chk_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      frame_ok_q <= 1'b0;
      chk_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      to_err_q   <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      chk_q      <= chk_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      frame_ok_q <= frame_ok_d;
      chk_err_q  <= chk_err_d;
      len_err_q  <= len_err_d;
      to_err_q   <= to_err_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign frame_ok = frame_ok_q;
  assign chk_err  = chk_err_q;
  assign len_err  = len_err_q;
  assign to_err   = to_err_q;
  assign ovf_err  = ovf_err_q;

endmodule
